imu_bias_corrector: RTL and testbench
=====================================

# imu_bias_corrector

Consumes the raw packed MPU6050 sample words (`{ay,ax}`, `{gx,az}`, `{gz,gy}`) produced by the I2C sensor front-end and delivers a bias-corrected, rate-strobed copy of them to the balance controller. After power-up it waits for the sensor to produce live data, then averages 2^CAL_LOG2 gyro samples to estimate the per-axis zero-rate offset. From then on it subtracts that offset from every gyro sample, with saturation, and emits one `valid_o` pulse per sample period. Accelerometer fields pass through unchanged.

## Interface
- `SAMPLE_DIV`, 100_000: clock cycles per sample period (1 kHz at 100 MHz); must be at least 2.
- `CAL_LOG2`, 8: log2 of the number of calibration samples (256).
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `data1_i` in 32: `{ay[15:0], ax[15:0]}`, signed two's complement.
- `data2_i` in 32: `{gx[15:0], az[15:0]}`.
- `data3_i` in 32: `{gz[15:0], gy[15:0]}`.
- `recal_i` in 1: one-cycle pulse that restarts calibration.
- `data1_o` out 32: `{ay, ax}`, passed through.
- `data2_o` out 32: `{gx_corr, az}`.
- `data3_o` out 32: `{gz_corr, gy_corr}`.
- `valid_o` out 1: one-cycle pulse; outputs are updated on this cycle.
- `cal_done_o` out 1: high while in ST_RUN.

## Operation
- **Tick counter**
  - Free-running, counts 0..SAMPLE_DIV-1 and wraps; starts at 0 on reset.
  - The sample tick is the cycle where count == SAMPLE_DIV-1. Inputs are sampled only on ticks.
- **States**
  - **ST_WAIT** (reset state)
    - On a tick where all six 16-bit fields are zero: discard the sample.
    - On a tick where any field is non-zero: clear the accumulators and sample counter, go to ST_CAL. That sample is not accumulated.
  - **ST_CAL**
    - On each tick, add sign-extended gx, gy, gz into three signed accumulators of 16+CAL_LOG2 bits each, and increment the sample counter.
    - On the 2^CAL_LOG2-th accumulated sample:
      - offset_x/y/z <= (acc + current sample) >>> CAL_LOG2. The shift is arithmetic, so the result is the floor.
      - Go to ST_RUN.
    - No `valid_o` is issued in this state.
  - **ST_RUN**
    - On each tick:
      - data1_o <= data1_i.
      - az passes through unchanged.
      - g_corr = sat16(g − offset). The difference is computed in 17 bits and clamped to [−32768, 32767].
      - valid_o pulses.
- **recal_i**
  - In ST_CAL or ST_RUN: clear the accumulators and counter and go to ST_CAL. `cal_done_o` drops. The offsets and data outputs hold their last values.
  - In ST_WAIT: ignored.
  - If recal_i coincides with a tick, recal wins: that sample is neither accumulated nor output, and `valid_o` stays 0.
- **Reset values**
  - All data outputs are 0; `valid_o` = 0; `cal_done_o` = 0.
  - Offsets, accumulators and counters are 0.
- **Asynchronous reset in any state** returns the block to ST_WAIT immediately. No output pulse is generated during or after reset.

## Timing
- Inputs are sampled at the tick edge.
- In ST_RUN, the outputs and `valid_o` are registered on that same edge and are visible for exactly one cycle after the tick cycle. `valid_o` is high for one cycle only.
- The offset registers and `cal_done_o` update on the edge of the final calibration tick. The first corrected output appears on the next tick, SAMPLE_DIV cycles later.
- The minimum time from the first non-zero tick to the first `valid_o` is (2^CAL_LOG2 + 1)·SAMPLE_DIV cycles.
- Outputs are stable between `valid_o` pulses.
- Input words are treated as quasi-static: no handshake with the upstream block. A sample may mix bytes from two consecutive sensor reads, and this is accepted.

## Test plan
Parameters: SAMPLE_DIV=4, CAL_LOG2=2.
- **Reset and wait:** rst_ni low, then high, with all inputs 0 for 20 ticks -> all outputs 0, `valid_o`=0, `cal_done_o`=0; the block stays in ST_WAIT.
- **Calibration:**
  - Stimulus: ax=1 to leave ST_WAIT, then gx=10,11,12,13, gy=−5,−6,−6,−7, gz=0.
  - Required: `cal_done_o` rises after the 4th tick; offsets are 11, −6, 0.
  - Next tick with gx=111, gy=−6, gz=5, az=0x4000 -> `valid_o` pulse, data2_o=0x00644000, data3_o[15:0]=0x0000, data3_o[31:16]=0x0005.
- **Floor rounding:** gx cal samples −1,−2,−2,−2 (sum −7) -> offset −2; input gx=0 -> gx_corr=2.
- **Saturation:**
  - offset_x=100, input gx=−32768 -> gx_corr=0x8000.
  - offset_y=−100, input gy=32767 -> gy_corr=0x7FFF.
- **Recalibration:**
  - recal_i pulsed in ST_RUN on a tick cycle -> no `valid_o` on that tick; `cal_done_o`=0; outputs hold.
  - After 4 further ticks with gx=50 -> offset_x=50; next gx=50 outputs 0.
- **Asynchronous reset mid-calibration:** rst_ni asserted between clock edges after 2 cal samples -> outputs are 0 immediately and `cal_done_o`=0. After release, the block requires non-zero data and a full 4-sample calibration before any `valid_o`.

Source files
------------

// File: rtl/imu_bias_corrector.sv
// imu_bias_corrector
//   Removes the zero-rate offset from the packed MPU6050 gyro words and hands
//   the balance controller a rate-strobed copy of the sensor sample. After
//   reset it waits for the first non-zero sample. It then averages
//   2^CAL_LOG2 gyro samples to estimate the per-axis offset. From then on it
//   outputs saturated, offset-corrected gyro values, once per sample period.
//
// Ports
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   data1_i     {ay, ax}  raw accelerometer X/Y (signed 16-bit each)
//   data2_i     {gx, az}  raw gyro X, accelerometer Z
//   data3_i     {gz, gy}  raw gyro Z/Y
//   recal_i     one-cycle pulse that restarts calibration (ignored in ST_WAIT)
//   data1_o     {ay, ax}            passed through
//   data2_o     {gx_corr, az}
//   data3_o     {gz_corr, gy_corr}
//   valid_o     one-cycle strobe; data outputs change only on this cycle
//   cal_done_o  high while corrected data is being produced (ST_RUN)
//
// Handshake: there is no handshake on the inputs. They are treated as
// quasi-static and sampled on the sample tick only. valid_o is a pure strobe
// with no ready: the consumer must capture the data while valid_o is high.
// The data outputs also hold their value until the next strobe.

module imu_bias_corrector #(
  parameter int SAMPLE_DIV = 100_000,
  parameter int CAL_LOG2   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [31:0] data3_i,
  input  logic        recal_i,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [31:0] data3_o,
  output logic        valid_o,
  output logic        cal_done_o
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int AW = 16 + CAL_LOG2;
  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [CAL_LOG2-1:0]   smp_cnt_q, smp_cnt_d;
  logic signed [AW-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
  logic [15:0]           off_x_q, off_x_d, off_y_q, off_y_d, off_z_q, off_z_d;
  logic [31:0]           data1_q, data1_d, data2_q, data2_d, data3_q, data3_d;
  logic                  valid_q, valid_d;

  logic                  tick;
  logic                  any_nonzero;
  logic                  cal_last;
  logic [15:0]           gx, gy, gz, az;
  logic signed [AW-1:0]  sum_x, sum_y, sum_z;

  assign tick        = (tick_cnt_q == TICK_LAST);
  assign any_nonzero = |{data1_i, data2_i, data3_i};
  // The sample counter holds the number already accumulated, so all-ones
  // means the current tick brings in the 2^CAL_LOG2-th sample.
  assign cal_last    = (smp_cnt_q == '1);

  assign az = data2_i[15:0];
  assign gx = data2_i[31:16];
  assign gy = data3_i[15:0];
  assign gz = data3_i[31:16];

  // The running sums include the current sample, so the final tick can form
  // the offset without an extra cycle.
  assign sum_x = acc_x_q + AW'($signed(gx));
  assign sum_y = acc_y_q + AW'($signed(gy));
  assign sum_z = acc_z_q + AW'($signed(gz));

  // 17-bit difference clamped back into the signed 16-bit range.
  function automatic logic [15:0] sat_sub(input logic [15:0] g, input logic [15:0] o);
    logic [16:0] d;
    d = {g[15], g} - {o[15], o};
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7FFF;
    return d[15:0];
  endfunction

  // State register and datapath flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_WAIT;
      tick_cnt_q <= '0;
      smp_cnt_q  <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      acc_z_q    <= '0;
      off_x_q    <= '0;
      off_y_q    <= '0;
      off_z_q    <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      data3_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      acc_z_q    <= acc_z_d;
      off_x_q    <= off_x_d;
      off_y_q    <= off_y_d;
      off_z_q    <= off_z_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      data3_q    <= data3_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic. recal_i takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: if (tick && any_nonzero) state_d = ST_CAL;
      ST_CAL:  if (!recal_i && tick && cal_last) state_d = ST_RUN;
      ST_RUN:  if (recal_i) state_d = ST_CAL;
      default: state_d = ST_WAIT;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    smp_cnt_d  = smp_cnt_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    acc_z_d    = acc_z_q;
    off_x_d    = off_x_q;
    off_y_d    = off_y_q;
    off_z_d    = off_z_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    data3_d    = data3_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        // The first live sample only starts calibration. It is not averaged.
        if (tick && any_nonzero) begin
          smp_cnt_d = '0;
          acc_x_d   = '0;
          acc_y_d   = '0;
          acc_z_d   = '0;
        end
      end
      ST_CAL, ST_RUN: begin
        if (recal_i) begin
          smp_cnt_d = '0;
          acc_x_d   = '0;
          acc_y_d   = '0;
          acc_z_d   = '0;
        end else if (tick && state_q == ST_CAL) begin
          smp_cnt_d = smp_cnt_q + 1'b1;
          acc_x_d   = sum_x;
          acc_y_d   = sum_y;
          acc_z_d   = sum_z;
          if (cal_last) begin
            // The arithmetic shift gives the floor of the mean.
            off_x_d = 16'(sum_x >>> CAL_LOG2);
            off_y_d = 16'(sum_y >>> CAL_LOG2);
            off_z_d = 16'(sum_z >>> CAL_LOG2);
          end
        end else if (tick) begin
          data1_d = data1_i;
          data2_d = {sat_sub(gx, off_x_q), az};
          data3_d = {sat_sub(gz, off_z_q), sat_sub(gy, off_y_q)};
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign data1_o    = data1_q;
  assign data2_o    = data2_q;
  assign data3_o    = data3_q;
  assign valid_o    = valid_q;
  assign cal_done_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_imu_bias_corrector.sv
// Directed bench for imu_bias_corrector with SAMPLE_DIV=4, CAL_LOG2=2.
// Ticks fall on every 4th rising edge after reset release. Reset is always
// released on a falling edge, so each run_tick call advances exactly one
// sample period. The checks are taken 1 ns after the rising edge.

module tb_imu_bias_corrector;

  logic        clk;
  logic        rst_n;
  logic [31:0] data1_i, data2_i, data3_i;
  logic        recal_i;
  logic [31:0] data1_o, data2_o, data3_o;
  logic        valid_o, cal_done_o;

  int n_cmp  = 0;
  int n_fail = 0;

  imu_bias_corrector #(.SAMPLE_DIV(4), .CAL_LOG2(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .data3_i    (data3_i),
    .recal_i    (recal_i),
    .data1_o    (data1_o),
    .data2_o    (data2_o),
    .data3_o    (data3_o),
    .valid_o    (valid_o),
    .cal_done_o (cal_done_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] az,
                        input logic [15:0] gx, input logic [15:0] gy, input logic [15:0] gz);
    data1_i = {ay, ax};
    data2_i = {gx, az};
    data3_i = {gz, gy};
  endtask

  // Advance one sample period. Optionally raise recal_i for the tick cycle.
  // valid_o must be low on the three non-tick edges.
  task automatic run_tick(input logic do_recal);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("valid_between_ticks", {31'd0, valid_o}, 32'd0);
    end
    if (do_recal) recal_i = 1'b1;
    @(posedge clk); #1;
    recal_i = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] e3, input logic ev, input logic ed);
    check({tag, "_data1"}, data1_o, e1);
    check({tag, "_data2"}, data2_o, e2);
    check({tag, "_data3"}, data3_o, e3);
    check({tag, "_valid"}, {31'd0, valid_o}, {31'd0, ev});
    check({tag, "_cal_done"}, {31'd0, cal_done_o}, {31'd0, ed});
  endtask

  initial begin
    rst_n   = 1'b0;
    recal_i = 1'b0;
    set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check_outs("in_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset and wait: all-zero samples never leave ST_WAIT.
    for (int t = 0; t < 20; t++) begin
      run_tick(1'b0);
      check("wait_cal_done", {31'd0, cal_done_o}, 32'd0);
    end
    check_outs("wait_end", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Calibration: ax=1 leaves ST_WAIT, then 4 gyro samples.
    set_in(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    run_tick(1'b0);
    check_outs("leave_wait", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_in(16'h0001, 16'h0, 16'h0, 16'h000A, 16'hFFFB, 16'h0); run_tick(1'b0);
    check("cal1_done", {31'd0, cal_done_o}, 32'd0);
    set_in(16'h0001, 16'h0, 16'h0, 16'h000B, 16'hFFFA, 16'h0); run_tick(1'b0);
    check("cal2_done", {31'd0, cal_done_o}, 32'd0);
    set_in(16'h0001, 16'h0, 16'h0, 16'h000C, 16'hFFFA, 16'h0); run_tick(1'b0);
    check("cal3_done", {31'd0, cal_done_o}, 32'd0);
    set_in(16'h0001, 16'h0, 16'h0, 16'h000D, 16'hFFF9, 16'h0); run_tick(1'b0);
    check_outs("cal4", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    // offsets 11, -6, 0
    set_in(16'h0001, 16'h0, 16'h4000, 16'h006F, 16'hFFFA, 16'h0005); run_tick(1'b0);
    check_outs("run1", 32'h0000_0001, 32'h0064_4000, 32'h0005_0000, 1'b1, 1'b1);

    // Recalibration on a tick: no strobe, outputs hold.
    set_in(16'h0, 16'h0, 16'h0, 16'h1234, 16'h1234, 16'h1234); run_tick(1'b1);
    check_outs("recal_tick", 32'h0000_0001, 32'h0064_4000, 32'h0005_0000, 1'b0, 1'b0);
    // gx=50 x4 -> 50 ; gy -1,-2,-2,-2 (sum -7) -> floor -2 ; gz 0
    set_in(16'h0, 16'h0, 16'h0, 16'h0032, 16'hFFFF, 16'h0); run_tick(1'b0);
    set_in(16'h0, 16'h0, 16'h0, 16'h0032, 16'hFFFE, 16'h0); run_tick(1'b0);
    set_in(16'h0, 16'h0, 16'h0, 16'h0032, 16'hFFFE, 16'h0); run_tick(1'b0);
    check("recal_cal3_done", {31'd0, cal_done_o}, 32'd0);
    set_in(16'h0, 16'h0, 16'h0, 16'h0032, 16'hFFFE, 16'h0); run_tick(1'b0);
    check_outs("recal_cal4", 32'h0000_0001, 32'h0064_4000, 32'h0005_0000, 1'b0, 1'b1);
    set_in(16'h0007, 16'h0008, 16'h1234, 16'h0032, 16'h0000, 16'h0000); run_tick(1'b0);
    check_outs("floor_run", 32'h0008_0007, 32'h0000_1234, 32'h0000_0002, 1'b1, 1'b1);

    // Second recal: offsets 100, -100, floor(15/4)=3.
    run_tick(1'b1);
    check("recal2_valid", {31'd0, valid_o}, 32'd0);
    set_in(16'h0, 16'h0, 16'h0, 16'h0064, 16'hFF9C, 16'h0003); run_tick(1'b0);
    set_in(16'h0, 16'h0, 16'h0, 16'h0064, 16'hFF9C, 16'h0004); run_tick(1'b0);
    set_in(16'h0, 16'h0, 16'h0, 16'h0064, 16'hFF9C, 16'h0004); run_tick(1'b0);
    set_in(16'h0, 16'h0, 16'h0, 16'h0064, 16'hFF9C, 16'h0004); run_tick(1'b0);
    check("recal2_cal_done", {31'd0, cal_done_o}, 32'd1);
    // Saturation at both ends.
    set_in(16'h0, 16'h0, 16'h0000, 16'h8000, 16'h7FFF, 16'h8000); run_tick(1'b0);
    check_outs("sat", 32'h0, 32'h8000_0000, 32'h8000_7FFF, 1'b1, 1'b1);
    // Near the rails without clamping: 32767-100, -32768+100, 0-3.
    set_in(16'h0, 16'h0, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000); run_tick(1'b0);
    check_outs("near_rail", 32'h0, 32'h7F9B_0000, 32'hFFFD_8064, 1'b1, 1'b1);

    // Asynchronous reset after 2 calibration samples.
    run_tick(1'b1);
    set_in(16'h0, 16'h0, 16'h0, 16'h0032, 16'h0, 16'h0); run_tick(1'b0);
    run_tick(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    run_tick(1'b0);
    run_tick(1'b0);
    check_outs("post_rst_wait", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_in(16'h0005, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0); run_tick(1'b0);
    check("post_rst_leave_done", {31'd0, cal_done_o}, 32'd0);
    for (int t = 0; t < 3; t++) begin
      set_in(16'h0005, 16'h0, 16'h0, 16'h0008, 16'h0, 16'h0); run_tick(1'b0);
      check("post_rst_cal_done", {31'd0, cal_done_o}, 32'd0);
      check("post_rst_cal_valid", {31'd0, valid_o}, 32'd0);
    end
    set_in(16'h0005, 16'h0, 16'h0, 16'h0008, 16'h0, 16'h0); run_tick(1'b0);
    check_outs("post_rst_cal4", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    set_in(16'h0005, 16'h0, 16'h00AA, 16'h0008, 16'h0001, 16'hFFFF); run_tick(1'b0);
    check_outs("post_rst_run", 32'h0000_0005, 32'h0000_00AA, 32'hFFFF_0001, 1'b1, 1'b1);
    run_tick(1'b0);
    check("post_rst_hold_data3", data3_o, 32'hFFFF_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
